// File: rtl/sensor_link_pkg.sv
// Shared types and constants for the sensor link controller: state codes,
// status codes and result word layout.
package sensor_link_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_TX   = 3'd2,
        S_COLLECT   = 3'd3,
        S_CHECK     = 3'd4,
        S_FINISH    = 3'd5,
        S_ALARM_ACK = 3'd6
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_CHKFAIL = 2'b10;

    localparam int RES_STATUS_LSB  = 30;
    localparam int RES_RETRY_LSB   = 28;
    localparam int RES_ALARM_BIT   = 27;
    localparam int RES_PAYLOAD_LSB = 0;
    localparam int RES_PAYLOAD_W   = 24;

    function automatic logic [31:0] pack_result(input logic [1:0]  status,
                                                input logic [1:0]  retries,
                                                input logic        alarm_flag,
                                                input logic [23:0] payload);
        logic [31:0] r;
        r = '0;
        r[RES_STATUS_LSB +: 2]                = status;
        r[RES_RETRY_LSB +: 2]                 = retries;
        r[RES_ALARM_BIT]                      = alarm_flag;
        r[RES_PAYLOAD_LSB +: RES_PAYLOAD_W]   = payload;
        return r;
    endfunction

endpackage

// File: rtl/sensor_link_ctrl_frame_rx.sv
// Response frame collector: stores payload plus checksum bytes, runs the
// per-byte timeout down-counter and compares the XOR checksum.
module sensor_frame_rx #(
    parameter int         PAYLOAD_BYTES  = 2,
    parameter logic [7:0] CHK_KEY        = 8'h37,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        active,
    input  logic        rx_hold,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        byte_clr,
    output logic        frame_full,
    output logic        tmo_hit,
    output logic        frame_ok,
    output logic        frame_bad,
    output logic        frame_timeout,
    output logic [7:0]  byte0,
    output logic [23:0] payload
);

    localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] LAST_IDX = 2'(PAYLOAD_BYTES);

    logic [7:0]       buf_q [4];
    logic [1:0]       idx_q;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_flag_q;
    logic             byte_take;
    logic [7:0]       chk_calc;

    // rx_hold masks the stale ready flag in the cycle after a clear
    assign byte_take  = active && rx_rdy && !rx_hold;
    assign byte_clr   = byte_take;
    assign frame_full = byte_take && (idx_q == LAST_IDX);
    assign tmo_hit    = active && !byte_take && (tmo_q == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            tmo_q      <= '0;
            tmo_flag_q <= 1'b0;
            for (int i = 0; i < 4; i++) buf_q[i[1:0]] <= '0;
        end else if (start) begin
            idx_q      <= '0;
            tmo_q      <= TMO_LOAD;
            tmo_flag_q <= 1'b0;
            for (int i = 0; i < 4; i++) buf_q[i[1:0]] <= '0;
        end else if (active) begin
            if (byte_take) begin
                buf_q[idx_q] <= rx_data;
                idx_q        <= idx_q + 2'd1;
                tmo_q        <= TMO_LOAD;
            end else if (tmo_q == '0) begin
                tmo_flag_q <= 1'b1;
            end else begin
                tmo_q <= tmo_q - TMO_W'(1);
            end
        end
    end

    always_comb begin
        chk_calc = CHK_KEY;
        payload  = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < PAYLOAD_BYTES) begin
                chk_calc            = chk_calc ^ buf_q[i[1:0]];
                payload[i*8 +: 8]   = buf_q[i[1:0]];
            end
        end
    end

    assign byte0         = buf_q[0];
    assign frame_timeout = tmo_flag_q;
    assign frame_ok      = !tmo_flag_q && (chk_calc == buf_q[LAST_IDX]);
    assign frame_bad     = !tmo_flag_q && (chk_calc != buf_q[LAST_IDX]);

endmodule

// File: rtl/sensor_link_ctrl.sv
// Nios custom-instruction front end for the Arduino sensor link: request,
// response collection with retries, and unsolicited alarm handling.
//
// state     | meaning
// IDLE      | waiting for enable or an unsolicited byte
// SEND      | waiting for transmitter free, then pulses tx_wr
// WAIT_TX   | waiting for tx_busy to rise and fall
// COLLECT   | gathering payload + checksum bytes
// CHECK     | checksum verdict, retry or finish decision
// FINISH    | done pulse with result
// ALARM_ACK | estado view of SEND/WAIT_TX while acknowledging an alarm
module sensor_link_ctrl
    import sensor_link_pkg::*;
#(
    parameter int         PAYLOAD_BYTES  = 2,
    parameter logic [7:0] CHK_KEY        = 8'h37,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter int         MAX_RETRIES    = 2,
    parameter logic [7:0] ALARM_CODE     = 8'h00,
    parameter logic [7:0] ALARM_ACK      = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic [2:0]  estado,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        rx_rdy_clr,
    output logic        alarm
);

    localparam logic [1:0] MAX_R = 2'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [7:0]  req_q;
    logic [1:0]  retries_q;
    logic [1:0]  status_q;
    logic        ack_mode_q;
    logic        unsol_q;
    logic        tx_seen_q;
    logic        clear_op_q;
    logic        alarm_q;
    logic        clr_q;
    logic        rx_new;
    logic        start_rx;

    logic        byte_clr, frame_full, tmo_hit;
    logic        frame_ok, frame_bad, frame_timeout;
    logic [7:0]  byte0;
    logic [23:0] payload;
    logic        alarm_frame;
    logic        unused_dataa;

    assign unused_dataa = ^{dataa[30:8], frame_bad};
    assign rx_new       = rx_rdy && !clr_q;
    assign alarm_frame  = frame_ok && (byte0 == ALARM_CODE);

    sensor_frame_rx #(
        .PAYLOAD_BYTES (PAYLOAD_BYTES),
        .CHK_KEY       (CHK_KEY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clock        (clock),
        .reset        (reset),
        .start        (start_rx),
        .active       (state_q == S_COLLECT),
        .rx_hold      (clr_q),
        .rx_data      (rx_data),
        .rx_rdy       (rx_rdy),
        .byte_clr     (byte_clr),
        .frame_full   (frame_full),
        .tmo_hit      (tmo_hit),
        .frame_ok     (frame_ok),
        .frame_bad    (frame_bad),
        .frame_timeout(frame_timeout),
        .byte0        (byte0),
        .payload      (payload)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_rx = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = dataa[31] ? S_FINISH : S_SEND;
                end else if (rx_new) begin
                    state_d  = S_COLLECT;
                    start_rx = 1'b1;
                end
            end
            S_SEND: begin
                if (!tx_busy) state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_seen_q && !tx_busy) begin
                    if (ack_mode_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_COLLECT;
                        start_rx = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (frame_full)   state_d = S_CHECK;
                else if (tmo_hit) state_d = unsol_q ? S_IDLE : S_CHECK;
            end
            S_CHECK: begin
                if (unsol_q)                  state_d = alarm_frame ? S_SEND : S_IDLE;
                else if (frame_ok)            state_d = S_FINISH;
                else if (retries_q < MAX_R)   state_d = S_SEND;
                else                          state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q      <= '0;
            retries_q  <= '0;
            status_q   <= ST_OK;
            ack_mode_q <= 1'b0;
            unsol_q    <= 1'b0;
            tx_seen_q  <= 1'b0;
            clear_op_q <= 1'b0;
            alarm_q    <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            clr_q     <= rx_rdy_clr;
            tx_seen_q <= (state_q == S_WAIT_TX) && (tx_seen_q || tx_busy);
            case (state_q)
                S_IDLE: begin
                    if (enable && dataa[31]) begin
                        alarm_q    <= 1'b0;
                        clear_op_q <= 1'b1;
                    end else if (enable) begin
                        req_q      <= dataa[7:0];
                        retries_q  <= '0;
                        ack_mode_q <= 1'b0;
                        unsol_q    <= 1'b0;
                        clear_op_q <= 1'b0;
                    end else if (rx_new) begin
                        unsol_q    <= 1'b1;
                        ack_mode_q <= 1'b0;
                    end
                end
                S_CHECK: begin
                    // alarm frames are honoured even when they answer a request
                    if (alarm_frame) alarm_q <= 1'b1;
                    if (unsol_q) begin
                        if (alarm_frame) ack_mode_q <= 1'b1;
                    end else if (frame_ok) begin
                        status_q <= ST_OK;
                    end else if (retries_q < MAX_R) begin
                        retries_q <= retries_q + 2'd1;
                    end else begin
                        status_q <= frame_timeout ? ST_TIMEOUT : ST_CHKFAIL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_wr      = 1'b0;
        tx_data    = '0;
        rx_rdy_clr = byte_clr;
        done       = 1'b0;
        result     = '0;
        estado     = state_q;
        case (state_q)
            S_SEND: begin
                tx_wr   = !tx_busy;
                tx_data = ack_mode_q ? ALARM_ACK : req_q;
                // flush any byte left pending when enable won over rx_rdy
                rx_rdy_clr = rx_new;
                if (ack_mode_q) estado = S_ALARM_ACK;
            end
            S_WAIT_TX: begin
                if (ack_mode_q) estado = S_ALARM_ACK;
            end
            S_FINISH: begin
                done = 1'b1;
                if (!clear_op_q) result = pack_result(status_q, retries_q, alarm_q, payload);
            end
            default: ;
        endcase
    end

    assign alarm = alarm_q;

endmodule

// File: tb/tb_sensor_link_ctrl.sv
// Directed bench for sensor_link_ctrl with a small uart byte model that
// answers each request attempt from a per-vector frame table.
module tb_sensor_link_ctrl;

    localparam int TIMEOUT = 255;
    localparam int TXB     = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] result;
    logic        done;
    logic [2:0]  estado;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        rx_rdy_clr;
    logic        alarm;

    always #5 clock = ~clock;

    sensor_link_ctrl #(
        .PAYLOAD_BYTES(2), .CHK_KEY(8'h37), .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_RETRIES(2), .ALARM_CODE(8'h00), .ALARM_ACK(8'hA5)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .dataa(dataa),
        .result(result), .done(done), .estado(estado), .tx_data(tx_data),
        .tx_wr(tx_wr), .tx_busy(tx_busy), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .rx_rdy_clr(rx_rdy_clr), .alarm(alarm)
    );

    typedef struct {
        logic [7:0]  req;
        bit          a_valid;
        logic [23:0] frame_a;
        bit          b_valid;
        logic [23:0] frame_b;
        logic [31:0] exp_result;
        int          exp_wr;
        int          exp_gap;
        logic        exp_alarm;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          tx_cnt = 0;
    bit          tx_prev = 0;
    logic [7:0]  rx_q [$];
    int          rx_gap = 0;
    bit          clr_seen = 0;
    int          n_wr = 0;
    logic [7:0]  wr_byte [16];
    int          wr_cyc [16];
    int          n_done = 0;
    logic [31:0] last_result = '0;
    bit          saw6 = 0;
    bit          clr_in_send = 0;
    bit          en_req = 0;
    logic [31:0] d_req = '0;
    bit          rst_drive = 1;
    bit          a_valid = 0, b_valid = 0;
    logic [23:0] frame_a = '0, frame_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [23:0] f);
        rx_q.push_back(f[7:0]);
        rx_q.push_back(f[15:8]);
        rx_q.push_back(f[23:16]);
    endtask

    // Inputs change on the falling edge; #1 later the outputs show what the
    // next rising edge will act on.
    task automatic tick();
        int att;
        @(negedge clock);
        reset  = rst_drive;
        enable = en_req;
        dataa  = d_req;
        en_req = 0;
        if (clr_seen) begin
            rx_rdy   = 1'b0;
            rx_gap   = 2;
            clr_seen = 0;
        end
        tx_busy = (tx_cnt > 0);
        if (tx_cnt > 0) tx_cnt--;
        if (tx_prev && !tx_busy) begin
            att = n_wr - 1;
            if (att == 0 && a_valid) push_frame(frame_a);
            else if (att > 0 && b_valid) push_frame(frame_b);
            rx_gap = 2;
        end
        tx_prev = tx_busy;
        if (rx_gap > 0) rx_gap--;
        else if (!rx_rdy && rx_q.size() > 0) begin
            rx_data = rx_q.pop_front();
            rx_rdy  = 1'b1;
        end
        #1;
        cyc++;
        if (tx_wr) begin
            if (n_wr < 16) begin
                wr_byte[n_wr] = tx_data;
                wr_cyc[n_wr]  = cyc;
            end
            n_wr++;
            tx_cnt = TXB;
        end
        if (rx_rdy_clr) begin
            clr_seen = 1;
            if (estado == 3'd1) clr_in_send = 1;
        end
        if (done) begin
            n_done++;
            last_result = result;
        end
        if (estado == 3'd6) saw6 = 1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        n_wr = 0; n_done = 0; saw6 = 0; clr_in_send = 0;
        last_result = 32'hDEAD_BEEF;
        a_valid = 0; b_valid = 0; frame_a = '0; frame_b = '0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) tick();
        ticks(12);
    endtask

    task automatic request(input logic [31:0] d);
        d_req  = d;
        en_req = 1;
        wait_done(3000);
    endtask

    vec_t vecs [7];

    initial begin
        // {req, a_valid, frame_a {chk,b1,b0}, b_valid, frame_b, result, tx count, retry gap, alarm}
        vecs[0] = '{8'h05, 1, 24'h11_34_12, 0, 24'h0,        32'h0000_3412, 1, 0,               1'b0};
        vecs[1] = '{8'h05, 0, 24'h0,        0, 24'h0,        32'h6000_0000, 3, TXB+TIMEOUT+3,   1'b0};
        vecs[2] = '{8'h05, 1, 24'hFF_34_12, 1, 24'h11_34_12, 32'h1000_3412, 2, 0,               1'b0};
        vecs[3] = '{8'h0A, 1, 24'hFF_34_12, 1, 24'hFF_34_12, 32'hA000_3412, 3, 0,               1'b0};
        vecs[4] = '{8'h3C, 1, 24'h51_CD_AB, 0, 24'h0,        32'h0000_CDAB, 1, 0,               1'b0};
        vecs[5] = '{8'h7F, 0, 24'h0,        1, 24'h34_02_01, 32'h1000_0201, 2, TXB+TIMEOUT+3,   1'b0};
        vecs[6] = '{8'h11, 1, 24'h32_05_00, 0, 24'h0,        32'h0800_0500, 1, 0,               1'b1};

        ticks(3);
        chk("rst_estado", {29'b0, estado}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_tx_wr", {31'b0, tx_wr}, 32'd0);
        chk("rst_rx_clr", {31'b0, rx_rdy_clr}, 32'd0);
        chk("rst_alarm", {31'b0, alarm}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        rst_drive = 0;
        ticks(3);

        for (int v = 0; v < 7; v++) begin
            clear_counts();
            a_valid = vecs[v].a_valid; frame_a = vecs[v].frame_a;
            b_valid = vecs[v].b_valid; frame_b = vecs[v].frame_b;
            request({24'h0, vecs[v].req});
            chk($sformatf("v%0d_done_cnt", v), n_done, 1);
            chk($sformatf("v%0d_result", v), last_result, vecs[v].exp_result);
            chk($sformatf("v%0d_tx_cnt", v), n_wr, vecs[v].exp_wr);
            chk($sformatf("v%0d_tx_byte", v), {24'b0, wr_byte[0]}, {24'b0, vecs[v].req});
            chk($sformatf("v%0d_alarm", v), {31'b0, alarm}, {31'b0, vecs[v].exp_alarm});
            if (vecs[v].exp_gap != 0 && n_wr >= 2)
                chk($sformatf("v%0d_retry_gap", v), wr_cyc[1] - wr_cyc[0], vecs[v].exp_gap);
        end

        // clear command drops the alarm left by the last vector
        clear_counts();
        request(32'h8000_0000);
        chk("clr_done_cnt", n_done, 1);
        chk("clr_result", last_result, 32'd0);
        chk("clr_alarm", {31'b0, alarm}, 32'd0);
        chk("clr_tx_cnt", n_wr, 0);

        // unsolicited alarm frame in idle
        clear_counts();
        push_frame(24'h37_00_00);
        ticks(60);
        chk("ualm_alarm", {31'b0, alarm}, 32'd1);
        chk("ualm_tx_cnt", n_wr, 1);
        chk("ualm_tx_byte", {24'b0, wr_byte[0]}, 32'h0000_00A5);
        chk("ualm_estado6", {31'b0, saw6}, 32'd1);
        chk("ualm_no_done", n_done, 0);
        chk("ualm_idle", {29'b0, estado}, 32'd0);

        clear_counts();
        a_valid = 1; frame_a = 24'h11_34_12;
        request(32'h0000_0005);
        chk("alm_req_result", last_result, 32'h0800_3412);

        clear_counts();
        request(32'h8000_0000);
        chk("clr2_result", last_result, 32'd0);
        chk("clr2_alarm", {31'b0, alarm}, 32'd0);

        // unsolicited valid frame that is not an alarm
        clear_counts();
        push_frame(24'h34_02_01);
        ticks(60);
        chk("unon_alarm", {31'b0, alarm}, 32'd0);
        chk("unon_tx_cnt", n_wr, 0);
        chk("unon_done", n_done, 0);

        // unsolicited partial frame times out silently
        clear_counts();
        rx_q.push_back(8'h55);
        ticks(320);
        chk("upart_tx_cnt", n_wr, 0);
        chk("upart_done", n_done, 0);
        chk("upart_idle", {29'b0, estado}, 32'd0);

        // enable and rx_rdy in the same cycle
        clear_counts();
        rx_q.push_back(8'h99);
        a_valid = 1; frame_a = 24'h11_34_12;
        request(32'h0000_0005);
        chk("race_flush", {31'b0, clr_in_send}, 32'd1);
        chk("race_result", last_result, 32'h0000_3412);
        chk("race_tx_cnt", n_wr, 1);

        // reset while collecting
        begin
            bit reached;
            clear_counts();
            reached = 0;
            d_req = 32'h0000_0005; en_req = 1;
            for (int i = 0; i < 50 && !reached; i++) begin
                tick();
                if (estado == 3'd3) reached = 1;
            end
            chk("rstc_reached_collect", {31'b0, reached}, 32'd1);
            rst_drive = 1;
            tick();
            chk("rstc_estado", {29'b0, estado}, 32'd0);
            chk("rstc_done", {31'b0, done}, 32'd0);
            rst_drive = 0;
            tick();
            rx_q.delete(); rx_rdy = 0; rx_gap = 0; clr_seen = 0;
            tx_cnt = 0; tx_prev = 0;
            clear_counts();
            ticks(300);
            chk("rstc_no_done", n_done, 0);
            chk("rstc_no_tx", n_wr, 0);
            a_valid = 1; frame_a = 24'h11_34_12;
            request(32'h0000_0005);
            chk("rstc_after_result", last_result, 32'h0000_3412);
            chk("rstc_after_done", n_done, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_link_ctrl.md
Name: sensor_link_ctrl

Overview:
Parametrised successor to the single-byte Nios/UART sensor request state machine.
- On a Nios custom-instruction start, sends a request byte to the Arduino sensor over the existing uart byte interface.
- Collects a PAYLOAD_BYTES response frame plus checksum, retries on timeout or checksum error, and returns a status-coded 32-bit result with a one-cycle done pulse.
- Also monitors the idle line for unsolicited alarm frames, acknowledges them and keeps a sticky alarm flag.

Parameters:
PAYLOAD_BYTES, 2, response payload bytes before the checksum byte (1..3)
CHK_KEY, 8'h37, checksum key; checksum = XOR of all payload bytes ^ CHK_KEY
TIMEOUT_CYCLES, 255, maximum clocks waited for each response byte (>=2)
MAX_RETRIES, 2, re-sends allowed after a failure (0..3)
ALARM_CODE, 8'h00, payload byte 0 value marking an unsolicited alarm frame
ALARM_ACK, 8'hA5, byte transmitted to silence the alarm

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  custom-instruction start, one-cycle pulse
dataa  in  32  [7:0] request code; [31]=1 means clear-alarm command
result  out  32  status word, valid while done=1
done  out  1  one-cycle completion pulse
estado  out  3  current state code
tx_data  out  8  byte to uart din
tx_wr  out  1  uart wr_en, one-cycle pulse
tx_busy  in  1  uart transmitter busy
rx_data  in  8  uart dout
rx_rdy  in  1  uart byte ready
rx_rdy_clr  out  1  uart ready clear, one-cycle pulse
alarm  out  1  sticky alarm flag

Behaviour:
Reset: all outputs 0 and state IDLE. Byte buffer, retry counter and timeout counter are cleared. Reset mid-operation aborts with no done pulse.

Result format:
- [31:30] status: 00 OK, 01 timeout, 10 checksum fail.
- [29:28] retries used.
- [27] alarm flag.
- [23:0] payload, byte0 in [7:0]; unused bytes 0.

States and estado codes:
- IDLE (0):
  - enable with dataa[31]=1: clear alarm, done pulse next cycle, result 0.
  - enable with dataa[31]=0: latch dataa[7:0], retries:=0, go to SEND.
  - Else rx_rdy: go to COLLECT in unsolicited mode.
  - enable beats rx_rdy in the same cycle; any pending rx byte is then flushed by rx_rdy_clr in SEND.
- SEND (1): when tx_busy=0, pulse tx_wr with tx_data = request (or ALARM_ACK in ack mode), then go to WAIT_TX.
- WAIT_TX (2):
  - Wait for tx_busy to rise, then fall.
  - Ack mode returns to IDLE.
  - Otherwise clear the byte index and timeout counter, then go to COLLECT.
- COLLECT (3):
  - On rx_rdy, store rx_data at the byte index, pulse rx_rdy_clr and reset the timeout counter.
  - Do not sample rx_rdy again in the cycle after a clear.
  - After PAYLOAD_BYTES+1 bytes, go to CHECK.
  - Timeout counter increments each cycle without a byte. When it reaches TIMEOUT_CYCLES, flag a timeout and go to CHECK; unsolicited mode returns to IDLE silently.
- CHECK (4), one cycle:
  - Compute XOR of the payload bytes ^ CHK_KEY and compare with the checksum byte.
  - Unsolicited mode: valid frame with byte0==ALARM_CODE sets alarm and enters SEND in ack mode; anything else returns to IDLE.
  - Request mode: valid frame goes to FINISH with status OK.
  - Request mode, failure with retries<MAX_RETRIES: retries++, go to SEND.
  - Request mode, failure with retries at the limit: FINISH with status 01 or 10.
- FINISH (5): drive result, pulse done for one cycle, return to IDLE.
- ALARM_ACK (6): ack mode is shown on estado=6 during SEND/WAIT_TX in ack mode.

Other rules:
- enable outside IDLE is ignored.
- Once an alarm frame is received, alarm stays 1 until the clear command; valid frames with byte0==ALARM_CODE received while a request is in progress are also treated as alarm frames.
- Minimum latency from enable to done is the tx time plus the rx time plus 3 cycles.

Decomposition:
Shared package sensor_link_pkg holds:
- state enum with its explicit 3-bit codes;
- status constants ST_OK, ST_TIMEOUT, ST_CHKFAIL;
- result field bit positions.

One natural sub-module, sensor_frame_rx, covers the byte collector, timeout counter and checksum compare. It signals frame_ok, frame_bad and frame_timeout to the top-level FSM.

Test Plan:
- Request 0x05; reply 0x12,0x34,0x11 -> one tx_wr of 0x05, done once, result 0x0000_3412.
- Request 0x05, no reply, MAX_RETRIES=2 -> three tx_wr of 0x05, each attempt waiting 255 cycles, then result 0x6000_0000.
- Reply 0x12,0x34,0xFF, then on retry 0x12,0x34,0x11 -> result 0x1000_3412.
- Unsolicited 0x00,0x00,0x37 in IDLE -> alarm=1 and tx_wr of 0xA5. Next request returns result[27]=1. Clear command (dataa=0x8000_0000) -> done, result 0, alarm=0.
- enable and rx_rdy in the same cycle in IDLE -> SEND taken and rx_rdy_clr pulsed. Reset asserted in COLLECT -> estado=0, no done, next request works normally.
